mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
//  Parametrised N-channel arbiter/mux between processor units and the shared block memory.
//  Replaces direct wiring of all PU memory ports onto one bus.
//  Round-robin or fixed-priority selection, locked bursts capped at MAX_BURST beats.
//  Per-channel read-return routing with a configurable memory read latency.
// PARAMETERS
//  NUM_CH     4   number of requesting channels (>=2)
//  ADDR_W     10  memory address width
//  DATA_W     96  memory data width (BLOCK_SIZE*WORD_SIZE)
//  READ_LAT   1   cycles from read beat to in_mem_rdata valid (>=1)
//  MAX_BURST  8   max consecutive beats per grant (>=1)
// PORTS
//  in_clk         in   1              clock, all logic on rising edge
//  in_reset       in   1              synchronous, active-high reset
//  in_mode        in   1              0 = round-robin, 1 = fixed priority (lowest index wins)
//  in_req         in   NUM_CH         per-channel access request
//  in_we          in   NUM_CH         per-channel write (1) / read (0)
//  in_lock        in   NUM_CH         request to keep grant for further beats
//  in_addr        in   NUM_CH*ADDR_W  packed addresses, ch i at [i*ADDR_W +: ADDR_W]
//  in_wdata       in   NUM_CH*DATA_W  packed write data, same packing
//  out_gnt        out  NUM_CH         registered one-hot grant
//  out_rvalid     out  NUM_CH         one-cycle read-return strobe for owning channel
//  out_rdata      out  DATA_W         read data, broadcast; valid where out_rvalid[i]
//  out_mem_addr   out  ADDR_W         to memory
//  out_mem_wdata  out  DATA_W         to memory
//  out_mem_we     out  1              memory write enable
//  out_mem_re     out  1              memory read enable
//  in_mem_rdata   in   DATA_W         from memory
//  out_busy       out  1              1 while state==OWN or reads are in flight
// BEHAVIOUR
//  Reset values: out_gnt=0, out_rvalid=0, out_mem_we=0, out_mem_re=0; state=IDLE; rr_ptr=0; beat_cnt=0.
//  Reset also flushes the read pipe.
//  FSM: IDLE, OWN. Owner w = index of out_gnt.
//  Arbitration, evaluated at the edge:
//   - RR: first requester searching from rr_ptr upward, wrapping at NUM_CH.
//   - FP: lowest requesting index.
//  IDLE: any in_req -> out_gnt<=onehot(winner), beat_cnt<=0, state<=OWN. First beat is the cycle after request.
//  Beat: any OWN cycle with in_req[w]=1.
//   - out_mem_addr/wdata muxed combinationally from channel w.
//   - out_mem_we = in_we[w]; out_mem_re = ~in_we[w].
//   - With no beat, out_mem_we and out_mem_re are both 0.
//  Release from OWN, at the edge of the triggering cycle, when any of:
//   (a) in_req[w]=0
//   (b) beat with in_lock[w]=0
//   (c) beat with beat_cnt==MAX_BURST-1
//  On release:
//   - rr_ptr <= (w+1) mod NUM_CH.
//   - If another channel requests: direct handoff, out_gnt<=onehot(next winner), beat_cnt<=0, stay OWN.
//     Next winner is chosen excluding w in RR; in FP it includes w only if (a) did not fire.
//   - Otherwise out_gnt<=0, state<=IDLE.
//  No release: beat_cnt increments on each beat; a non-beat cycle never occurs (it is release (a)).
//  Read return: each read beat pushes {valid, w} into a READ_LAT-deep shift pipe.
//   - READ_LAT cycles later: out_rvalid[id]=1 for one cycle, out_rdata=in_mem_rdata.
//   - Returns are in issue order, one per cycle; back-to-back reads allowed.
//  in_mode changes take effect at the next arbitration decision only; the current owner is not preempted.
//  Mid-operation reset discards in-flight reads; no out_rvalid follows reset.
//  Requests are level-held; channels must keep in_addr/we/wdata stable while in_req=1 and not yet beat-accepted.
// TESTING
//  1 Reset: hold in_reset 2 cycles with all in_req=1 -> out_gnt=0, no mem enables, out_busy=0.
//  2 RR fairness, mode=0: all 4 req, lock=0, single beats -> grants 0,1,2,3,0 on consecutive cycles.
//    One mem op per cycle, no idle gaps.
//  3 Burst cap, MAX_BURST=8: ch2 lock=1 and req held 20 cycles, ch0 also req -> exactly 8 beats of ch2,
//    then ch3? no (not requesting) -> ch0 granted next cycle.
//  4 Read routing, READ_LAT=2: ch1 reads addr 5, then ch3 reads addr 9 -> out_rvalid[1] 2 cycles after beat 1
//    with mem[5], out_rvalid[3] the next cycle with mem[9].
//  5 FP mode: ch0 and ch3 requesting continuously, lock=0 -> ch0 granted every cycle, ch3 never.
//    Switch to mode=0 -> ch3 granted within 2 cycles.
//  6 Reset during burst: ch1 bursting with 1 read in flight, assert in_reset -> next cycle out_gnt=0,
//    no out_rvalid ever for that read.

Source files
------------

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// mem_access_arbiter : N-channel round-robin / fixed-priority arbiter onto one
//                      shared block memory, with locked bursts and read routing.
// Revision           : 1.0
// ============================================================================
module mem_access_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 96,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_mode,
  input  logic [NUM_CH-1:0]        in_req,
  input  logic [NUM_CH-1:0]        in_we,
  input  logic [NUM_CH-1:0]        in_lock,
  input  logic [NUM_CH*ADDR_W-1:0] in_addr,
  input  logic [NUM_CH*DATA_W-1:0] in_wdata,
  output logic [NUM_CH-1:0]        out_gnt,
  output logic [NUM_CH-1:0]        out_rvalid,
  output logic [DATA_W-1:0]        out_rdata,
  output logic [ADDR_W-1:0]        out_mem_addr,
  output logic [DATA_W-1:0]        out_mem_wdata,
  output logic                     out_mem_we,
  output logic                     out_mem_re,
  input  logic [DATA_W-1:0]        in_mem_rdata,
  output logic                     out_busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [CH_W-1:0]     pipe_id_q [READ_LAT];
  logic [CH_W-1:0]     pipe_id_d [READ_LAT];

  logic [CH_W-1:0]     w;
  logic [CH_W-1:0]     w_next;
  logic                own_req, own_we, own_lock;
  logic                beat, release_own;
  logic [NUM_CH-1:0]   arb_req;
  logic [CH_W-1:0]     arb_ptr;
  logic [CH_W:0]       arb_res;

  // Returns {found, index}; fp selects lowest index, otherwise search from ptr with wrap.
  function automatic logic [CH_W:0] pick(input logic [NUM_CH-1:0] req,
                                         input logic              fp,
                                         input logic [CH_W-1:0]   ptr);
    logic            found;
    logic [CH_W-1:0] idx;
    int              k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = fp ? i : (int'(ptr) + i) % NUM_CH;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = CH_W'(k);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    w             = '0;
    out_mem_addr  = '0;
    out_mem_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_q[i]) begin
        w             = CH_W'(i);
        out_mem_addr  = in_addr[i*ADDR_W +: ADDR_W];
        out_mem_wdata = in_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign own_req  = |(in_req & gnt_q);
  assign own_we   = |(in_we & gnt_q);
  assign own_lock = |(in_lock & gnt_q);
  assign w_next   = (w == CH_W'(NUM_CH - 1)) ? '0 : w + CH_W'(1);

  assign beat        = (state_q == S_OWN) && own_req;
  assign release_own = (state_q == S_OWN) &&
                       (!own_req || !own_lock || (beat_cnt_q == BC_W'(MAX_BURST - 1)));

  assign out_mem_we = beat & own_we;
  assign out_mem_re = beat & ~own_we;

  // On handoff in RR the outgoing owner is never re-selected; in FP it may
  // win again, which only happens if it is still requesting.
  always_comb begin
    if (state_q == S_IDLE) begin
      arb_req = in_req;
      arb_ptr = rr_ptr_q;
    end else begin
      arb_req = in_mode ? in_req : (in_req & ~gnt_q);
      arb_ptr = w_next;
    end
    arb_res = pick(arb_req, in_mode, arb_ptr);
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arb_res[CH_W]) begin
          gnt_d      = {{(NUM_CH-1){1'b0}}, 1'b1} << arb_res[CH_W-1:0];
          beat_cnt_d = '0;
          state_d    = S_OWN;
        end
      end
      S_OWN: begin
        if (release_own) begin
          rr_ptr_d = w_next;
          if (arb_res[CH_W]) begin
            gnt_d      = {{(NUM_CH-1){1'b0}}, 1'b1} << arb_res[CH_W-1:0];
            beat_cnt_d = '0;
          end else begin
            gnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + BC_W'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = out_mem_re;
    pipe_id_d[0]  = w;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      pipe_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      pipe_vld_q <= pipe_vld_d;
    end
    pipe_id_q <= pipe_id_d;
  end

  // Gated by reset so a return can never surface in the reset cycle itself.
  always_comb begin
    out_rvalid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_rvalid[i] = pipe_vld_q[READ_LAT-1] && !in_reset &&
                      (pipe_id_q[READ_LAT-1] == CH_W'(i));
    end
  end

  assign out_rdata = in_mem_rdata;
  assign out_gnt   = gnt_q;
  assign out_busy  = (state_q == S_OWN) || (|pipe_vld_q);

endmodule
`default_nettype wire
